// File: rtl/cpu_types_pkg.sv
// Shared fetch-stage types and buffer sizing.
// FETCH_SKID_EN selects a two-entry skid buffer instead of a single entry.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    FULL   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  typedef struct packed {
    word_t instr;
    word_t pc4;
  } fetch_entry_t;

`ifdef FETCH_SKID_EN
  localparam int unsigned FETCH_BUF_DEPTH = 2;
`else
  localparam int unsigned FETCH_BUF_DEPTH = 1;
`endif

endpackage

// File: rtl/fetch_if.sv
// Signal bundle between the fetch unit and its environment.
// Modport fu is the fetch unit's view; modport tb drives the unit.
interface fetch_if (input logic CLK);
  import cpu_types_pkg::*;

  logic  nRST;
  word_t pcout;
  logic  pcenable;
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  word_t instr;
  word_t instr_pc4;
  logic  instr_valid;
  logic  instr_ready;
  logic  flush;
  logic  halt;
  word_t fetch_count;

  modport fu (
    input  CLK, nRST, pcout, ihit, imemload, instr_ready, flush, halt,
    output pcenable, imemREN, imemaddr, instr, instr_pc4, instr_valid, fetch_count
  );

  modport tb (
    input  CLK, pcenable, imemREN, imemaddr, instr, instr_pc4, instr_valid, fetch_count,
    output nRST, pcout, ihit, imemload, instr_ready, flush, halt
  );
endinterface

// File: rtl/fetch_buffer.sv
// One- or two-entry FIFO between instruction memory and the IF/ID latch.
// Valid/ready on both sides; clear empties it synchronously.
module fetch_buffer
  import cpu_types_pkg::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         clear,
  input  logic         in_valid,
  output logic         in_ready,
  input  fetch_entry_t in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output fetch_entry_t out_data,
  output logic         full
);

  localparam logic [1:0] DEPTH_C = 2'(DEPTH);

  fetch_entry_t slot0, slot1;
  logic [1:0]   count;
  logic         push, pop;

  assign out_valid = (count != 2'd0);
  assign full      = (count == DEPTH_C);
  assign pop       = out_valid && out_ready;
  // Space exists if not full, or if the head leaves this same cycle.
  assign in_ready  = !full || pop;
  assign push      = in_valid && in_ready;
  assign out_data  = slot0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      slot0 <= '0;
      slot1 <= '0;
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= in_data;
          else               slot1 <= in_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= in_data;
          end else begin
            slot0 <= slot1;
            slot1 <= in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: requests imem at pcout, buffers words for IF/ID.
// Define FETCH_SKID_EN for a two-entry buffer (see cpu_types_pkg).
module fetch_unit
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  word_t pcout,
  output logic  pcenable,
  output logic  imemREN,
  output word_t imemaddr,
  input  logic  ihit,
  input  word_t imemload,
  output word_t instr,
  output word_t instr_pc4,
  output logic  instr_valid,
  input  logic  instr_ready,
  input  logic  flush,
  input  logic  halt,
  output word_t fetch_count
);

  fetch_state_t state;
  word_t        fetch_count_q;
  fetch_entry_t cap_data, head;
  logic         buf_in_ready, buf_full, buf_clear;
  logic         fire, accept;

  assign imemaddr    = pcout;
  // A FETCH cycle with a full, undrained buffer issues no request.
  assign imemREN     = (state == FETCH) && buf_in_ready;
  assign fire        = imemREN && ihit && !flush;
  assign accept      = instr_valid && instr_ready;
  assign pcenable    = nRST && (state != HALTED) && (flush || fire);
  assign buf_clear   = flush || halt || (state == HALTED);
  assign cap_data    = '{instr: imemload, pc4: pcout + 32'd4};
  assign instr       = head.instr;
  assign instr_pc4   = head.pc4;
  assign fetch_count = fetch_count_q;

  fetch_buffer #(.DEPTH(FETCH_BUF_DEPTH)) u_buf (
    .CLK       (CLK),
    .nRST      (nRST),
    .clear     (buf_clear),
    .in_valid  (fire),
    .in_ready  (buf_in_ready),
    .in_data   (cap_data),
    .out_valid (instr_valid),
    .out_ready (instr_ready),
    .out_data  (head),
    .full      (buf_full)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state         <= FETCH;
      fetch_count_q <= '0;
    end else begin
      if (accept) fetch_count_q <= fetch_count_q + 32'd1;
      case (state)
        FETCH: begin
          if (flush)                     state <= FETCH;
          else if (halt)                 state <= HALTED;
          else if (buf_full && !accept)  state <= FULL;
          else                           state <= FETCH;
        end
        FULL: begin
          if (flush)       state <= FETCH;
          else if (halt)   state <= HALTED;
          else if (accept) state <= FETCH;
          else             state <= FULL;
        end
        HALTED:  state <= HALTED;
        default: state <= FETCH;
      endcase
    end
  end

endmodule
